ext_freq_meter_ctrl: RTL and testbench
======================================

// Module: ext_freq_meter_ctrl
// PURPOSE
//  Gated edge-count controller for an external pin such as D16. Synchronises the async input and
//  detects rising edges. Sequences fixed-length gate windows, counts edges only inside a window,
//  and latches the count as a frequency result (edges per window). Feeds LED/status logic on board.
// PARAMETERS
//  GATE_CYCLES  32000000  gate window length in CLK_IN cycles; >=4
//  CNT_W        16        width of edge counter and result
// PORTS
//  CLK_IN     in   1      single system clock; all logic on posedge
//  RST_N_i    in   1      synchronous, active-low reset
//  SIG_i      in   1      async external signal, 0..3.3V
//  START_i    in   1      level; sampled in IDLE only, starts one measurement
//  ABORT_i    in   1      level; cancels an ARM/GATE measurement
//  BUSY_o     out  1      high in ARM and GATE
//  DONE_o     out  1      1-cycle pulse when RESULT_o updates
//  VALID_o    out  1      RESULT_o holds a completed measurement
//  OVF_o      out  1      latched with RESULT_o: edge counter saturated in that window
//  RESULT_o   out  CNT_W  edge count of last completed window
// BEHAVIOUR
//  Reset (RST_N_i=0 at posedge): state=IDLE; all outputs 0; sync flops, counters and gate timer 0.
//   Reset is valid mid-measurement and discards that measurement.
//  Input sync: sync0<=SIG_i; sync1<=sync0; last<=sync1; edge = sync1 & ~last.
//   Sync chain runs in every state. Pin posedge -> edge high 2-3 cycles later; 1 cycle per posedge.
//  FSM states:
//   IDLE: START_i=1 -> ARM.
//   ARM: 1 cycle. cnt<=0, ovf<=0, gate_tmr<=GATE_CYCLES-1. -> GATE (ABORT_i -> IDLE).
//   GATE: each cycle, if edge: cnt<=cnt+1, or ovf<=1 with cnt held when cnt=all-ones (saturate).
//    gate_tmr decrements. The window is exactly GATE_CYCLES cycles in GATE.
//    Edge on the last GATE cycle is counted. gate_tmr=0 -> DONE.
//    ABORT_i=1 -> IDLE; cnt discarded; RESULT_o/VALID_o/OVF_o unchanged.
//   DONE: 1 cycle. RESULT_o<=cnt (final edge included); OVF_o<=ovf; VALID_o<=1; DONE_o=1 this cycle.
//    -> IDLE (see CONFIGURATION).
//  Edges in IDLE/ARM/DONE are never counted.
//  START_i outside IDLE is ignored. ABORT_i wins over START_i in ARM/GATE. ABORT_i in IDLE/DONE is ignored.
//  BUSY_o is a registered decode of state. IDLE->ARM->GATE: BUSY_o rises the cycle after START is sampled.
//  Min START->DONE_o latency = GATE_CYCLES+2 cycles. RESULT_o and OVF_o are stable except in DONE.
// CONFIGURATION
//  FREQ_METER_AUTORUN_EN defined: DONE -> ARM unconditionally. Back-to-back windows with 2-cycle dead time (DONE, ARM).
//   START_i is needed only to leave IDLE after reset/abort. ABORT_i returns to IDLE as above.
//  Undefined: DONE -> IDLE. Each measurement needs a new START_i.
// TESTING (GATE_CYCLES=100, CNT_W=16 unless stated)
//  1 Reset then idle 20 cycles, SIG_i toggling -> all outputs 0, BUSY_o=0, no DONE_o.
//  2 START 1 cycle. 7 SIG_i pulses (4 high/4 low) starting 10 cycles into GATE
//    -> DONE_o once at START+102; RESULT_o=7; VALID_o=1; OVF_o=0.
//  3 CNT_W=4, 20 pulses inside window -> RESULT_o=15, OVF_o=1.
//    Next run with 3 pulses -> RESULT_o=3, OVF_o=0.
//  4 Valid result 7, new START, 5 pulses, ABORT_i at gate cycle 50
//    -> IDLE next cycle, no DONE_o, RESULT_o stays 7.
//    START_i held during GATE has no effect.
//  5 Edge timed to reach edge on the final GATE cycle -> counted.
//    Edge one cycle later (in DONE) -> not counted.
//    RST_N_i=0 mid-GATE -> all outputs 0 next cycle.
//  6 FREQ_METER_AUTORUN_EN, 1 START, SIG_i period 8 -> DONE_o every 102 cycles.
//    RESULT_o in {12,13} each window.

Source files
------------

// File: rtl/ext_freq_meter_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : ext_freq_meter_ctrl
// Description : Gated edge-count frequency meter for an external pin.
//               SIG_i is synchronised (two flops) and its rising edges are
//               detected. A measurement runs ARM -> GATE (exactly GATE_CYCLES
//               cycles) -> DONE. Rising edges seen during GATE are counted
//               with saturation, and the count is latched as RESULT_o
//               (edges per window).
// Parameters  : GATE_CYCLES - gate window length in CLK_IN cycles (>= 4)
//               CNT_W       - width of the edge counter and RESULT_o
// Ports       : CLK_IN    - system clock, all logic on its rising edge
//               RST_N_i   - synchronous active-low reset
//               SIG_i     - asynchronous external signal
//               START_i   - level, sampled in IDLE only, starts a measurement
//               ABORT_i   - level, cancels a measurement in ARM/GATE
//               BUSY_o    - high while in ARM or GATE
//               DONE_o    - one-cycle pulse in the DONE state
//               VALID_o   - RESULT_o holds a completed measurement
//               OVF_o     - edge counter saturated in the reported window
//               RESULT_o  - edge count of the last completed window
// Config      : FREQ_METER_AUTORUN_EN - when defined, DONE returns to ARM so
//               windows repeat back to back (two dead cycles: DONE, ARM).
//               When undefined, DONE returns to IDLE.
// Revision    : 1.0 - initial release
// ============================================================================
module ext_freq_meter_ctrl #(
    parameter int GATE_CYCLES = 32000000,
    parameter int CNT_W       = 16
) (
    input  logic             CLK_IN,
    input  logic             RST_N_i,
    input  logic             SIG_i,
    input  logic             START_i,
    input  logic             ABORT_i,
    output logic             BUSY_o,
    output logic             DONE_o,
    output logic             VALID_o,
    output logic             OVF_o,
    output logic [CNT_W-1:0] RESULT_o
);

    // Timer must hold GATE_CYCLES-1; GATE_CYCLES >= 4 keeps the width >= 2.
    localparam int              TMR_W      = $clog2(GATE_CYCLES);
    localparam logic [TMR_W-1:0] C_TMR_LOAD = TMR_W'(GATE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_GATE = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic             r_sync0;
    logic             r_sync1;
    logic             r_last;
    logic             w_edge;

    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf;
    logic [TMR_W-1:0] r_tmr;

    logic             r_busy;
    logic             r_done;
    logic             r_valid;
    logic             r_ovf_out;
    logic [CNT_W-1:0] r_result;

    assign w_edge = r_sync1 & ~r_last;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK_IN) begin
        if (!RST_N_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic; ABORT_i has priority over everything in ARM/GATE
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (START_i) begin
                    w_state_nxt = S_ARM;
                end
            end
            S_ARM: begin
                if (ABORT_i) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_GATE;
                end
            end
            S_GATE: begin
                if (ABORT_i) begin
                    w_state_nxt = S_IDLE;
                end else if (r_tmr == '0) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
`ifdef FREQ_METER_AUTORUN_EN
                w_state_nxt = S_ARM;
`else
                w_state_nxt = S_IDLE;
`endif
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Input synchroniser and edge history; runs in every state
    // ------------------------------------------------------------------
    always_ff @(posedge CLK_IN) begin
        if (!RST_N_i) begin
            r_sync0 <= 1'b0;
            r_sync1 <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            r_sync0 <= SIG_i;
            r_sync1 <= r_sync0;
            r_last  <= r_sync1;
        end
    end

    // ------------------------------------------------------------------
    // Counter, gate timer and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK_IN) begin
        if (!RST_N_i) begin
            r_cnt     <= '0;
            r_ovf     <= 1'b0;
            r_tmr     <= '0;
            r_valid   <= 1'b0;
            r_ovf_out <= 1'b0;
            r_result  <= '0;
        end else begin
            case (r_state)
                S_ARM: begin
                    r_cnt <= '0;
                    r_ovf <= 1'b0;
                    r_tmr <= C_TMR_LOAD;
                end
                S_GATE: begin
                    // The edge seen on the last GATE cycle (timer at 0) is
                    // still counted; DONE then latches the final count.
                    if (w_edge) begin
                        if (&r_cnt) begin
                            r_ovf <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    if (r_tmr != '0) begin
                        r_tmr <= r_tmr - TMR_W'(1);
                    end
                end
                S_DONE: begin
                    r_result  <= r_cnt;
                    r_ovf_out <= r_ovf;
                    r_valid   <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Status flags registered from the next state so they line up with
    // the state they describe and come out of reset low.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK_IN) begin
        if (!RST_N_i) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt == S_ARM) || (w_state_nxt == S_GATE);
            r_done <= (w_state_nxt == S_DONE);
        end
    end

    assign BUSY_o   = r_busy;
    assign DONE_o   = r_done;
    assign VALID_o  = r_valid;
    assign OVF_o    = r_ovf_out;
    assign RESULT_o = r_result;

endmodule
`default_nettype wire

// File: tb/tb_ext_freq_meter_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_ext_freq_meter_ctrl
// Description : Directed self-checking bench for ext_freq_meter_ctrl with
//               GATE_CYCLES=100. A second instance with CNT_W=4 covers
//               counter saturation. The final scenario follows the
//               FREQ_METER_AUTORUN_EN setting of the build.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ext_freq_meter_ctrl;

    localparam int GATE = 100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sig;
    logic        start;
    logic        start4;
    logic        abort_in;

    logic        busy, done, valid, ovf;
    logic [15:0] result;
    logic        busy4, done4, valid4, ovf4;
    logic [3:0]  result4;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int ndone = 0;
    int s     = 0;
    int lat   = 0;

    always #5 clk = ~clk;

    ext_freq_meter_ctrl #(.GATE_CYCLES(GATE), .CNT_W(16)) dut (
        .CLK_IN   (clk),
        .RST_N_i  (rst_n),
        .SIG_i    (sig),
        .START_i  (start),
        .ABORT_i  (abort_in),
        .BUSY_o   (busy),
        .DONE_o   (done),
        .VALID_o  (valid),
        .OVF_o    (ovf),
        .RESULT_o (result)
    );

    ext_freq_meter_ctrl #(.GATE_CYCLES(GATE), .CNT_W(4)) dut4 (
        .CLK_IN   (clk),
        .RST_N_i  (rst_n),
        .SIG_i    (sig),
        .START_i  (start4),
        .ABORT_i  (abort_in),
        .BUSY_o   (busy4),
        .DONE_o   (done4),
        .VALID_o  (valid4),
        .OVF_o    (ovf4),
        .RESULT_o (result4)
    );

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (done) ndone++;
    endtask

    task automatic pulses(input int n, input int hi, input int lo);
        for (int i = 0; i < n; i++) begin
            sig = 1'b1;
            repeat (hi) tick();
            sig = 1'b0;
            repeat (lo) tick();
        end
    endtask

    // START for one cycle on the main instance; s marks the sampling edge.
    task automatic start_main();
        start = 1'b1;
        tick();
        start = 1'b0;
        s = cyc;
    endtask

    task automatic wait_done_main(input string name);
        while (!done && (cyc - s) < 300) tick();
        lat = cyc - s;
        n_cmp++;
        if (!done) begin
            n_err++;
            $display("FAIL %s_timeout: DONE_o not seen within %0d cycles", name, lat);
        end
    endtask

    task automatic wait_done4(input string name);
        while (!done4 && (cyc - s) < 300) tick();
        n_cmp++;
        if (!done4) begin
            n_err++;
            $display("FAIL %s_timeout: DONE_o (CNT_W=4) not seen", name);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; sig = 1'b0; start = 1'b0; start4 = 1'b0; abort_in = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            sig = ~sig;
            tick();
        end
        n_cmp++;
        if ({busy, done, valid, ovf, result} !== 20'h0) begin
            n_err++;
            $display("FAIL reset_outputs: got busy=%b done=%b valid=%b ovf=%b result=%0d, want all 0",
                     busy, done, valid, ovf, result);
        end
        n_cmp++;
        if ({busy4, done4, valid4, ovf4, result4} !== 8'h0) begin
            n_err++;
            $display("FAIL reset_outputs4: got busy=%b valid=%b ovf=%b result=%0d, want all 0",
                     busy4, valid4, ovf4, result4);
        end
        n_cmp++;
        if (ndone !== 0) begin
            n_err++;
            $display("FAIL reset_no_done: got %0d DONE pulses, want 0", ndone);
        end
    endtask

    task automatic test_count();
        sig = 1'b0;
        repeat (4) tick();
        ndone = 0;
        start_main();
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL busy_rise: got %b, want 1", busy);
        end
        repeat (10) tick();
        pulses(7, 4, 4);
        wait_done_main("count");
        n_cmp++;
        if (lat !== GATE + 1) begin
            n_err++;
            $display("FAIL done_latency: got %0d, want %0d cycles after START edge", lat, GATE + 1);
        end
        tick();
        n_cmp++;
        if (result !== 16'd7 || valid !== 1'b1 || ovf !== 1'b0) begin
            n_err++;
            $display("FAIL count_result: got result=%0d valid=%b ovf=%b, want 7 1 0", result, valid, ovf);
        end
        repeat (5) tick();
        n_cmp++;
        if (ndone !== 1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL count_single_done: got %0d pulses busy=%b, want 1 pulse busy=0", ndone, busy);
        end
    endtask

    task automatic test_saturate();
        sig = 1'b0;
        repeat (4) tick();
        start4 = 1'b1; tick(); start4 = 1'b0; s = cyc;
        pulses(20, 2, 2);
        wait_done4("sat");
        tick();
        n_cmp++;
        if (result4 !== 4'd15 || ovf4 !== 1'b1 || valid4 !== 1'b1) begin
            n_err++;
            $display("FAIL saturate: got result=%0d ovf=%b valid=%b, want 15 1 1", result4, ovf4, valid4);
        end
        repeat (4) tick();
        start4 = 1'b1; tick(); start4 = 1'b0; s = cyc;
        pulses(3, 2, 2);
        wait_done4("sat2");
        tick();
        n_cmp++;
        if (result4 !== 4'd3 || ovf4 !== 1'b0) begin
            n_err++;
            $display("FAIL saturate_clear: got result=%0d ovf=%b, want 3 0", result4, ovf4);
        end
    endtask

    task automatic test_abort();
        sig = 1'b0;
        repeat (4) tick();
        ndone = 0;
        start = 1'b1;          // held high through ARM and into GATE
        tick();
        s = cyc;
        repeat (2) tick();
        pulses(5, 4, 4);
        n_cmp++;
        if (busy !== 1'b1 || ndone !== 0) begin
            n_err++;
            $display("FAIL start_held: got busy=%b dones=%0d, want busy=1 dones=0", busy, ndone);
        end
        start = 1'b0;
        while ((cyc - s) < 50) tick();
        abort_in = 1'b1;
        tick();
        abort_in = 1'b0;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL abort_idle: got busy=%b, want 0", busy);
        end
        repeat (120) tick();
        n_cmp++;
        if (ndone !== 0 || result !== 16'd7 || valid !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL abort_keep: got dones=%0d result=%0d valid=%b busy=%b, want 0 7 1 0",
                     ndone, result, valid, busy);
        end
    endtask

    task automatic test_boundary();
        // Rising pin 3 edges before the last GATE edge lands on that edge.
        sig = 1'b0;
        repeat (4) tick();
        start_main();
        repeat (GATE - 2) tick();
        sig = 1'b1;
        wait_done_main("last_edge");
        tick();
        n_cmp++;
        if (result !== 16'd1) begin
            n_err++;
            $display("FAIL last_gate_edge: got result=%0d, want 1", result);
        end
        sig = 1'b0;
        repeat (4) tick();
        start_main();
        repeat (GATE - 1) tick();
        sig = 1'b1;
        wait_done_main("done_edge");
        tick();
        n_cmp++;
        if (result !== 16'd0) begin
            n_err++;
            $display("FAIL edge_in_done: got result=%0d, want 0", result);
        end
        // Reset in the middle of a window.
        sig = 1'b0;
        repeat (4) tick();
        start_main();
        repeat (30) tick();
        rst_n = 1'b0;
        tick();
        n_cmp++;
        if ({busy, done, valid, ovf, result} !== 20'h0) begin
            n_err++;
            $display("FAIL reset_mid_gate: got busy=%b done=%b valid=%b ovf=%b result=%0d, want all 0",
                     busy, done, valid, ovf, result);
        end
        rst_n = 1'b1;
        repeat (2) tick();
    endtask

`ifdef FREQ_METER_AUTORUN_EN
    task automatic test_mode();
        int  last_d;
        int  nwin;
        bit  pend;
        last_d = -1; nwin = 0; pend = 1'b0;
        sig = 1'b0;
        repeat (4) tick();
        start_main();
        for (int i = 0; i < 420; i++) begin
            if (i % 4 == 0) sig = ~sig;
            tick();
            if (pend) begin
                n_cmp++;
                if (result !== 16'd12 && result !== 16'd13) begin
                    n_err++;
                    $display("FAIL autorun_result: got %0d, want 12 or 13", result);
                end
                pend = 1'b0;
            end
            if (done) begin
                if (last_d >= 0) begin
                    n_cmp++;
                    if (cyc - last_d !== GATE + 2) begin
                        n_err++;
                        $display("FAIL autorun_period: got %0d, want %0d", cyc - last_d, GATE + 2);
                    end
                end
                last_d = cyc;
                nwin++;
                pend = 1'b1;
            end
        end
        n_cmp++;
        if (nwin !== 4) begin
            n_err++;
            $display("FAIL autorun_windows: got %0d, want 4", nwin);
        end
        abort_in = 1'b1;
        tick();
        abort_in = 1'b0;
        tick();
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL autorun_abort: got busy=%b, want 0", busy);
        end
    endtask
`else
    task automatic test_mode();
        sig = 1'b0;
        repeat (4) tick();
        ndone = 0;
        start_main();
        for (int i = 0; i < 320; i++) begin
            if (i % 4 == 0) sig = ~sig;
            tick();
        end
        n_cmp++;
        if (ndone !== 1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL single_shot: got %0d pulses busy=%b, want 1 pulse busy=0", ndone, busy);
        end
        n_cmp++;
        if (result !== 16'd12 && result !== 16'd13) begin
            n_err++;
            $display("FAIL single_shot_result: got %0d, want 12 or 13", result);
        end
    endtask
`endif

    initial begin
        rst_n = 1'b0; sig = 1'b0; start = 1'b0; start4 = 1'b0; abort_in = 1'b0;
        test_reset();
        test_count();
        test_saturate();
        test_abort();
        test_boundary();
        test_mode();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
